// File: rtl/splinker_pump_driver.sv
// Sprinkler valve/pump sequencer: debounces the raw request, opens the valve ahead of the pump,
// bounds run time, drains the line, cools down, and latches a dry-run fault.
// Latency: req_db follows raw after DEBOUNCE edges; outputs are Moore decodes of registered state.
// Backpressure: none; a request during DRAIN/COOLDOWN/FAULT is simply not honoured until IDLE.
//
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   splinker_bomb           raw sprinkler request
//   water_empty             tank-empty sensor (1 = dry-run hazard)
//   valve_open, pump_on     actuator commands
//   fault                   dry-run fault latched (state FAULT)
//   busy                    any state other than IDLE
//   cycles_done             completed RUN periods, saturating at 255
module splinker_pump_driver #(
    parameter int DEBOUNCE   = 4,
    parameter int VALVE_LEAD = 3,
    parameter int MIN_RUN    = 8,
    parameter int MAX_RUN    = 64,
    parameter int DRAIN      = 3,
    parameter int COOLDOWN   = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       splinker_bomb,
    input  logic       water_empty,
    output logic       valve_open,
    output logic       pump_on,
    output logic       fault,
    output logic       busy,
    output logic [7:0] cycles_done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_VALVE_LEAD = 3'd1,
        S_RUN        = 3'd2,
        S_DRAIN      = 3'd3,
        S_COOLDOWN   = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(VALVE_LEAD - 1);
    localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(DRAIN - 1);
    localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(COOLDOWN - 1);
    localparam logic [CNT_W-1:0] RUN_MIN   = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(MAX_RUN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
    logic               req_db_q, req_db_d;
    logic [7:0]         cycles_done_q, cycles_done_d;

    // Cycles spent in the current state, counting the one ending at this edge.
    logic [CNT_W-1:0]   elapsed;
    logic               run_done;

    assign elapsed = timer_q + CNT_W'(1);

    // Debounce: count consecutive mismatches; toggle on the DEBOUNCE-th one.
    always_comb begin
        db_cnt_d = '0;
        req_db_d = req_db_q;
        if (splinker_bomb != req_db_q) begin
            if (db_cnt_q == DEB_LAST) begin
                req_db_d = ~req_db_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic. Dry-run has top priority wherever the pump could be spinning.
    always_comb begin
        state_d  = state_q;
        run_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_db_q && !water_empty) state_d = S_VALVE_LEAD;
            end
            S_VALVE_LEAD: begin
                if (water_empty)               state_d = S_FAULT;
                else if (!req_db_q)            state_d = S_DRAIN;
                else if (timer_q == LEAD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (water_empty) begin
                    state_d = S_FAULT;
                end else if (elapsed == RUN_MAX) begin
                    state_d  = S_DRAIN;
                    run_done = 1'b1;
                end else if (!req_db_q && elapsed >= RUN_MIN) begin
                    state_d  = S_DRAIN;
                    run_done = 1'b1;
                end
            end
            S_DRAIN: begin
                if (timer_q == DRN_LAST) state_d = S_COOLDOWN;
            end
            S_COOLDOWN: begin
                if (timer_q == CD_LAST) state_d = S_IDLE;
            end
            S_FAULT: begin
                // Request must drop too, so a stuck request cannot restart a dry pump.
                if (!water_empty && !req_db_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = elapsed;
        if (state_d != state_q || state_q == S_IDLE || state_q == S_FAULT) begin
            timer_d = '0;
        end
        cycles_done_d = cycles_done_q;
        if (run_done && cycles_done_q != 8'hFF) begin
            cycles_done_d = cycles_done_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            db_cnt_q      <= '0;
            req_db_q      <= 1'b0;
            cycles_done_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            db_cnt_q      <= db_cnt_d;
            req_db_q      <= req_db_d;
            cycles_done_q <= cycles_done_d;
        end
    end

    assign valve_open  = (state_q == S_VALVE_LEAD) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign pump_on     = (state_q == S_RUN);
    assign fault       = (state_q == S_FAULT);
    assign busy        = (state_q != S_IDLE);
    assign cycles_done = cycles_done_q;

endmodule
